// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side adapter for async_fifo, living entirely in the FIFO read clock
// domain. It pops the FIFO through r_en, captures the FIFO's combinational
// output word into a two-entry skid buffer (head + skid) and presents the
// buffered words on a valid/ready stream with registered data.
//
// Handshake rule for the output stream: a word moves from this block to the
// consumer on a rising clk edge where m_valid and m_ready are both 1.
// m_valid never drops and m_data never changes while m_valid is 1 and
// m_ready is 0.
//
// Optional feature: define FIFO_RD_STREAM_LAST_EN to build a burst counter
// that frames the stream into BURST_LEN-word bursts via m_last. Without the
// macro, m_last is tied to 0 and BURST_LEN has no effect on the logic.
//
// Parameters
//   DATA_WIDTH  word width, must match the upstream FIFO
//   BURST_LEN   words per burst for m_last framing (>= 2)
//
// Ports
//   clk        in   FIFO read clock; every register is on its rising edge
//   rst        in   asynchronous, active-low reset
//   empty      in   FIFO empty flag
//   fifo_data  in   FIFO output word, valid whenever empty is 0
//   r_en       out  FIFO read enable (combinational)
//   flush      in   synchronous discard of every buffered word
//   m_valid    out  m_data holds a word
//   m_ready    in   consumer accepts the word when m_valid is also 1
//   m_data     out  head word
//   m_last     out  head word is the final word of a burst
//   occupancy  out  buffered word count, 0..2 (also the buffer state)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  r_en,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [1:0]            occupancy
);

    // Elaboration-time sanity check on the burst length.
    if (BURST_LEN < 2) begin : g_bad_burst_len
        $error("fifo_rd_stream: BURST_LEN must be at least 2");
    end

    // Buffer count values. The count doubles as the state of the buffer.
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    logic [1:0]            cnt_q,  cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;

    logic push;   // a FIFO word is captured at this edge
    logic hs;     // output handshake at this edge

    // -------------------------------------------------------------------------
    // Output process: everything here is a function of the registered count,
    // except r_en which must react to empty/flush in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        m_valid   = (cnt_q != CNT_EMPTY);
        occupancy = cnt_q;
        // Reset is folded in so the FIFO is never popped while the pointers
        // it shares a reset net with are being cleared. With the buffer full
        // nothing is popped, even if the head leaves this cycle; the pop
        // resumes one cycle later.
        r_en      = rst & ~flush & ~empty & (cnt_q != CNT_FULL);
    end

    assign push   = r_en;
    assign hs     = m_valid & m_ready;
    assign m_data = head_q;

    // -------------------------------------------------------------------------
    // Next-state process for the count and the two data registers.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        skid_d = skid_q;

        if (flush) begin
            // A handshake in the flush cycle is ignored; words are dropped
            // and r_en is already 0 so the FIFO keeps its next word.
            cnt_d = CNT_EMPTY;
        end else begin
            case (cnt_q)
                CNT_EMPTY: begin
                    if (push) begin
                        head_d = fifo_data;
                        cnt_d  = CNT_ONE;
                    end
                end

                CNT_ONE: begin
                    if (push && hs) begin
                        // Head leaves and is replaced in the same edge:
                        // the steady full-throughput case.
                        head_d = fifo_data;
                    end else if (push) begin
                        skid_d = fifo_data;
                        cnt_d  = CNT_FULL;
                    end else if (hs) begin
                        cnt_d  = CNT_EMPTY;
                    end
                end

                default: begin
                    // Full: push is impossible here, only the head can leave.
                    if (hs) begin
                        head_d = skid_q;
                        cnt_d  = CNT_ONE;
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= CNT_EMPTY;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

`ifdef FIFO_RD_STREAM_LAST_EN
    // -------------------------------------------------------------------------
    // Burst framing: counts accepted words modulo BURST_LEN. The count
    // refers to the word currently at the head, so m_last marks the head as
    // the final word of its burst.
    // -------------------------------------------------------------------------
    localparam int              BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]   LAST_IDX = BW'(BURST_LEN - 1);

    logic [BW-1:0] burst_q, burst_d;

    always_comb begin
        burst_d = burst_q;
        if (flush) begin
            burst_d = '0;
        end else if (hs) begin
            burst_d = (burst_q == LAST_IDX) ? '0 : burst_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

    assign m_last = m_valid & (burst_q == LAST_IDX);
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Bench for fifo_rd_stream. The upstream FIFO is a queue of words (fifo_q)
// whose head drives fifo_data/empty. The adapter itself is modelled as an
// ordered queue of buffered words (exp_q, head first) plus a running count of
// accepted words for burst framing. Directed steps follow the test plan,
// then a randomized phase mixes FIFO fills, back-pressure, flushes and one
// mid-stream reset.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;
  localparam int W  = 16;
  localparam int BL = 4;
`ifdef FIFO_RD_STREAM_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         empty;
  logic [W-1:0] fifo_data;
  logic         r_en;
  logic         flush;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic [1:0]   occupancy;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .fifo_data (fifo_data),
    .r_en      (r_en),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .occupancy (occupancy)
  );

  // ---------------------------------------------------------------------------
  // Models and counters
  // ---------------------------------------------------------------------------
  logic [W-1:0] fifo_q[$];   // words still inside the upstream FIFO
  logic [W-1:0] exp_q[$];    // words held by the adapter, head first
  int           hs_count;    // words accepted since reset/flush
  int           n_pass;
  int           n_total;
  logic [W-1:0] next_word;

  logic         obs_hs;
  logic         obs_last;
  logic [W-1:0] obs_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic drive_fifo();
    empty = (fifo_q.size() == 0);
    // Garbage on the bus while empty so a bogus capture is visible.
    fifo_data = empty ? W'($urandom) : fifo_q[0];
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_word);
      next_word = next_word + 1'b1;
    end
    drive_fifo();
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the
  // models across the rising edge. Inputs are set by the caller beforehand.
  task automatic cycle();
    logic exp_valid, exp_ren, exp_last, dut_ren;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0);
    exp_ren   = rst && !flush && (fifo_q.size() != 0) && (exp_q.size() < 2);
    exp_last  = LAST_EN && exp_valid && ((hs_count % BL) == BL - 1);
    check("r_en",      32'(r_en),      32'(exp_ren));
    check("m_valid",   32'(m_valid),   32'(exp_valid));
    check("occupancy", 32'(occupancy), 32'(exp_q.size()));
    check("m_last",    32'(m_last),    32'(exp_last));
    if (exp_valid) check("m_data", 32'(m_data), 32'(exp_q[0]));
    obs_hs   = m_valid & m_ready;
    obs_last = m_last;
    obs_data = m_data;
    dut_ren  = r_en;
    @(posedge clk);
    #1;
    if (!rst || flush) begin
      exp_q.delete();
      hs_count = 0;
    end else begin
      if (exp_valid && m_ready) begin
        void'(exp_q.pop_front());
        hs_count++;
      end
      if (exp_ren) exp_q.push_back(fifo_q[0]);
    end
    if (dut_ren && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  // Stream with m_ready high until n handshakes happen, recording m_last of
  // each accepted word. Leaves m_ready low afterwards.
  task automatic stream_n(input int n, input string tag, output logic [15:0] last_mask);
    int got = 0;
    last_mask = '0;
    flush = 1'b0;
    for (int g = 0; g < 8 * n + 8 && got < n; g++) begin
      m_ready = 1'b1;
      cycle();
      if (obs_hs) begin
        last_mask[got] = obs_last;
        got++;
      end
    end
    m_ready = 1'b0;
    check({tag, "_hs_count"}, 32'(got), 32'(n));
  endtask

  task automatic drain();
    m_ready = 1'b1;
    flush   = 1'b0;
    for (int g = 0; g < 64 && (fifo_q.size() != 0 || exp_q.size() != 0); g++) cycle();
    @(negedge clk);
    check("drain_occupancy", 32'(occupancy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    flush   = 1'b1;
    m_ready = 1'b0;
    cycle();
    flush   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed steps followed by randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] mask;
    logic [W-1:0] want;
    int           seen;

    n_pass    = 0;
    n_total   = 0;
    hs_count  = 0;
    next_word = 16'h0001;
    flush     = 1'b0;
    m_ready   = 1'b1;
    rst       = 1'b1;
    load(8);                       // 0x0001..0x0008, so empty = 0
    #2 rst = 1'b0;

    // Reset: outputs quiet and no pops even though the FIFO is non-empty.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_m_data", 32'(m_data), 32'd0);
      @(posedge clk);
      #1;
      cycle();
    end
    rst = 1'b1;

    // Release: r_en in the first cycle, then 8 words on 8 consecutive cycles.
    cycle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("stream_hs",   32'(obs_hs),   32'd1);
      check("stream_data", 32'(obs_data), 32'(i + 1));
    end

    // Back-pressure: five stalled cycles mid-stream, then resume.
    load(12);                      // 0x0009..0x0014
    m_ready = 1'b1;
    cycle();
    cycle();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    @(negedge clk);
    check("bp_occupancy", 32'(occupancy), 32'd2);
    check("bp_r_en",      32'(r_en),      32'd0);
    @(posedge clk);
    #1;
    drain();

    // Empty boundary: a single word.
    fifo_q.push_back(16'hBEEF);
    drive_fifo();
    m_ready = 1'b0;
    cycle();
    cycle();
    @(negedge clk);
    check("single_data",  32'(m_data), 32'h0000BEEF);
    check("single_empty", 32'(empty),  32'd1);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    cycle();
    cycle();

    // Flush at occupancy 2; the next delivered word is the next unread one.
    load(4);
    m_ready = 1'b0;
    cycle();
    cycle();
    cycle();
    want = fifo_q[0];
    flush_pulse();
    seen = 0;
    for (int g = 0; g < 10 && seen == 0; g++) begin
      m_ready = 1'b1;
      cycle();
      if (obs_hs) begin
        check("flush_next_word", 32'(obs_data), 32'(want));
        seen = 1;
      end
    end
    check("flush_next_seen", 32'(seen), 32'd1);
    drain();

    // Burst framing: 10 words after a flush, then a flush after word 5.
    flush_pulse();
    load(10);
    stream_n(10, "burst10", mask);
    check("burst10_last", 32'(mask), LAST_EN ? 32'h0088 : 32'h0000);
    load(10);
    stream_n(5, "burst5", mask);
    flush_pulse();
    stream_n(4, "burst_after_flush", mask);
    check("burst_after_flush_last", 32'(mask), LAST_EN ? 32'h0008 : 32'h0000);
    drain();

    // Randomized traffic, with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        hs_count = 0;
        drive_fifo();
        cycle();
        rst = 1'b1;
      end
      if (fifo_q.size() < 16 && $urandom_range(0, 2) != 0) load(1);
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
